alu_mc_unit: RTL and testbench
==============================

ALU_MC_UNIT -- requirements
Module: alu_mc_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set operand/result width (legal 8..64, power of two).
REQ-002 Parameter MUL_EN, default 1, SHALL enable the iterative multiply path (0 = multiply decodes as illegal).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  operation request; in_ready  output  1  unit can accept.
REQ-006 alu_op  input  2  00 add, 01 sub, 10 funct-decoded, 11 multiply class.
REQ-007 funct3  input  3; funct7b5  input  1  instruction decode fields.
REQ-008 op_a, op_b  input  XLEN each  operands, sampled only at accept.
REQ-009 out_valid  output  1; out_ready  input  1  result handshake.
REQ-010 result  output  XLEN; zero  output  1 (result == 0); illegal  output  1; alu_ctrl  output  4  decoded op code, all registered.

Function
REQ-011 Accept SHALL occur on a cycle with in_valid & in_ready; in_ready SHALL be 1 only in IDLE.
REQ-012 Decode: alu_op 00 -> ADD 0010; 01 -> SUB 0110; 11 with funct3 000 and MUL_EN=1 -> MUL 1000.
REQ-013 alu_op 10 by funct3: 000 ADD/SUB (funct7b5=1 SUB); 001 SLL 0100; 010 SLT 0111; 011 SLTU 1111; 100 XOR 0011; 101 SRL 0101 / SRA 1101 (funct7b5=1); 110 OR 0001; 111 AND 0000.
REQ-014 Any other alu_op 11 combination SHALL complete as single-cycle with result 0, alu_ctrl 0010, illegal 1.
REQ-015 Arithmetic modulo 2^XLEN; SLT signed, SLTU unsigned, result 1 or 0 zero-extended.
REQ-016 Shift amount SHALL be op_b[log2(XLEN)-1:0]; SRA sign-fills from op_a[XLEN-1].
REQ-017 MUL SHALL return low XLEN bits of op_a*op_b via radix-2 shift-add, one multiplier bit per cycle.
REQ-018 FSM states IDLE, MUL, DONE; IDLE->DONE on accept of non-MUL op; IDLE->MUL on accept of MUL; MUL->DONE after exactly XLEN iteration cycles; DONE->IDLE when out_ready=1.
REQ-019 Latency: non-MUL out_valid asserted the cycle after accept; MUL out_valid asserted XLEN+1 cycles after accept.
REQ-020 In DONE, out_valid=1 and result/zero/illegal/alu_ctrl SHALL hold stable until out_ready; out_ready while not DONE SHALL be ignored.
REQ-021 out_ready=1 in DONE with in_valid=1 SHALL NOT accept in that cycle; next accept earliest the following cycle (IDLE).
REQ-022 Iteration counter width log2(XLEN)+1, no wrap before termination; MUL accumulator XLEN bits, overflow discarded.
REQ-023 Operand changes after accept SHALL NOT affect an in-flight operation.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force IDLE, in_ready=1 after release, out_valid=0, result=0, zero=0, illegal=0, alu_ctrl=0010, counter/accumulator=0.
REQ-025 Reset asserted mid-MUL or in DONE SHALL abort the operation with no result ever presented.
REQ-026 in_valid during reset SHALL be ignored.

Verification
REQ-027 XLEN=32: alu_op=10, funct3=000, funct7b5=1, a=5, b=7 -> next cycle out_valid, result=0xFFFFFFFE, alu_ctrl=0110, zero=0.
REQ-028 alu_op=10, funct3=101, funct7b5=1, a=0x80000000, b=4 -> result 0xF8000000 (SRA); funct7b5=0 -> 0x08000000; funct3=011, a=0xFFFFFFFF, b=1 -> result 0, zero=1.
REQ-029 alu_op=11, funct3=000, a=0xFFFF, b=0x10001 -> out_valid exactly 33 cycles after accept, result 0xFFFFFFFF, alu_ctrl=1000.
REQ-030 Hold out_ready=0 for 10 cycles after result -> out_valid, result stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-031 rst_n=0 at MUL iteration 10 -> out_valid never asserts for that op; next ADD 2+3 returns 5 with 1-cycle latency.
REQ-032 MUL_EN=0 or alu_op=11, funct3=010 -> result 0, illegal=1, 1-cycle latency.

Source files
------------

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result handshake bundle for alu_mc_unit.
//   master : drives request (in_valid, alu_op, funct3, funct7b5, op_a, op_b)
//            and out_ready; observes in_ready and the registered result group.
//   slave  : the ALU side of the same signals.
interface alu_mc_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      alu_op;
   logic [2:0]      funct3;
   logic            funct7b5;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;
   logic [3:0]      alu_ctrl;

   modport master (
      output in_valid, alu_op, funct3, funct7b5, op_a, op_b, out_ready,
      input  in_ready, out_valid, result, zero, illegal, alu_ctrl
   );

   modport slave (
      input  in_valid, alu_op, funct3, funct7b5, op_a, op_b, out_ready,
      output in_ready, out_valid, result, zero, illegal, alu_ctrl
   );
endinterface

// File: rtl/alu_mc_unit.sv
// alu_mc_unit: ALU with single-cycle ops and an iterative radix-2 multiplier.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_mc_if.slave -- accept handshake (in_valid/in_ready), decode
//           fields, operands, result handshake (out_valid/out_ready) and the
//           registered result, zero, illegal, alu_ctrl outputs.
// Parameters: XLEN operand width (8..64, power of two); MUL_EN enables MUL.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new request (in_ready=1)
// MUL   | shift-add multiply in progress, one multiplier bit per cycle
// DONE  | result presented (out_valid=1), held until out_ready
module alu_mc_unit #(
   parameter int XLEN   = 32,
   parameter bit MUL_EN = 1'b1
) (
   input logic     clk,
   input logic     rst_n,
   alu_mc_if.slave bus
);
   localparam int SHW = $clog2(XLEN);
   localparam int CW  = SHW + 1;

   localparam logic [3:0] CTRL_AND  = 4'b0000;
   localparam logic [3:0] CTRL_OR   = 4'b0001;
   localparam logic [3:0] CTRL_ADD  = 4'b0010;
   localparam logic [3:0] CTRL_XOR  = 4'b0011;
   localparam logic [3:0] CTRL_SLL  = 4'b0100;
   localparam logic [3:0] CTRL_SRL  = 4'b0101;
   localparam logic [3:0] CTRL_SUB  = 4'b0110;
   localparam logic [3:0] CTRL_SLT  = 4'b0111;
   localparam logic [3:0] CTRL_MUL  = 4'b1000;
   localparam logic [3:0] CTRL_SRA  = 4'b1101;
   localparam logic [3:0] CTRL_SLTU = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [3:0]      dec_ctrl;
   logic            dec_illegal;
   logic            dec_mul;
   logic [XLEN-1:0] alu_res;
   logic [SHW-1:0]  shamt;
   logic            slt, sltu;
   logic            accept;
   logic            last_iter;

   logic [XLEN-1:0] mcand, mplier, acc, acc_nxt;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] result_q;
   logic            zero_q, illegal_q;
   logic [3:0]      ctrl_q;

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.illegal   = illegal_q;
   assign bus.alu_ctrl  = ctrl_q;

   assign accept    = bus.in_valid && (state == S_IDLE);
   assign last_iter = (cnt == CW'(1));
   assign acc_nxt   = mplier[0] ? (acc + mcand) : acc;

   always_comb begin : decode
      dec_ctrl    = CTRL_ADD;
      dec_illegal = 1'b0;
      dec_mul     = 1'b0;
      case (bus.alu_op)
         2'b00: dec_ctrl = CTRL_ADD;
         2'b01: dec_ctrl = CTRL_SUB;
         2'b10: begin
            case (bus.funct3)
               3'b000: dec_ctrl = bus.funct7b5 ? CTRL_SUB : CTRL_ADD;
               3'b001: dec_ctrl = CTRL_SLL;
               3'b010: dec_ctrl = CTRL_SLT;
               3'b011: dec_ctrl = CTRL_SLTU;
               3'b100: dec_ctrl = CTRL_XOR;
               3'b101: dec_ctrl = bus.funct7b5 ? CTRL_SRA : CTRL_SRL;
               3'b110: dec_ctrl = CTRL_OR;
               default: dec_ctrl = CTRL_AND;
            endcase
         end
         default: begin
            if (MUL_EN && (bus.funct3 == 3'b000)) begin
               dec_ctrl = CTRL_MUL;
               dec_mul  = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
      endcase
   end

   assign shamt = bus.op_b[SHW-1:0];
   assign slt   = ($signed(bus.op_a) < $signed(bus.op_b));
   assign sltu  = (bus.op_a < bus.op_b);

   always_comb begin : alu
      alu_res = '0;
      case (dec_ctrl)
         CTRL_ADD:  alu_res = bus.op_a + bus.op_b;
         CTRL_SUB:  alu_res = bus.op_a - bus.op_b;
         CTRL_SLL:  alu_res = bus.op_a << shamt;
         CTRL_SLT:  alu_res = {{(XLEN-1){1'b0}}, slt};
         CTRL_SLTU: alu_res = {{(XLEN-1){1'b0}}, sltu};
         CTRL_XOR:  alu_res = bus.op_a ^ bus.op_b;
         CTRL_SRL:  alu_res = bus.op_a >> shamt;
         CTRL_SRA:  alu_res = $unsigned($signed(bus.op_a) >>> shamt);
         CTRL_OR:   alu_res = bus.op_a | bus.op_b;
         CTRL_AND:  alu_res = bus.op_a & bus.op_b;
         default:   alu_res = '0;
      endcase
      // Illegal ops decode to the ADD code but must still return zero.
      if (dec_illegal) alu_res = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin : fsm_next
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = dec_mul ? S_MUL : S_DONE;
         S_MUL:  if (last_iter) state_nxt = S_DONE;
         S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
         ctrl_q    <= CTRL_ADD;
      end else begin
         if (accept) begin
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
            if (dec_mul) begin
               mcand  <= bus.op_a;
               mplier <= bus.op_b;
               acc    <= '0;
               cnt    <= CW'(XLEN);
            end else begin
               result_q <= alu_res;
               zero_q   <= (alu_res == '0);
            end
         end
         if (state == S_MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            // The final partial product lands straight in the result so DONE
            // is entered on the same edge as the last iteration.
            if (last_iter) begin
               result_q <= acc_nxt;
               zero_q   <= (acc_nxt == '0);
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_mc_unit.sv
// Self-checking bench for alu_mc_unit (XLEN=32), plus a MUL_EN=0 instance.
module tb_alu_mc_unit;
   localparam int XLEN = 32;
   localparam int MUL_LAT = XLEN + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   alu_mc_if #(.XLEN(XLEN)) bus ();
   alu_mc_if #(.XLEN(XLEN)) bus_nm ();

   alu_mc_unit #(.XLEN(XLEN), .MUL_EN(1'b1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   alu_mc_unit #(.XLEN(XLEN), .MUL_EN(1'b0)) u_dut_nm (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_nm)
   );

   assign bus_nm.in_valid  = bus.in_valid;
   assign bus_nm.alu_op    = bus.alu_op;
   assign bus_nm.funct3    = bus.funct3;
   assign bus_nm.funct7b5  = bus.funct7b5;
   assign bus_nm.op_a      = bus.op_a;
   assign bus_nm.op_b      = bus.op_b;
   assign bus_nm.out_ready = 1'b1;

   typedef struct {
      logic [1:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  ctrl;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference: the operation semantics written directly as arithmetic.
   function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [3:0] c,
                                 output logic il, output int lat);
      logic [4:0] sh;
      sh = b[4:0];
      r = 32'd0; c = 4'b0010; il = 1'b0; lat = 1;
      if (op == 2'd0) r = a + b;
      else if (op == 2'd1) begin r = a - b; c = 4'b0110; end
      else if (op == 2'd2) begin
         if (f3 == 3'd0 && !f7) r = a + b;
         else if (f3 == 3'd0) begin r = a - b; c = 4'b0110; end
         else if (f3 == 3'd1) begin r = a << sh; c = 4'b0100; end
         else if (f3 == 3'd2) begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; c = 4'b0111; end
         else if (f3 == 3'd3) begin r = (a < b) ? 32'd1 : 32'd0; c = 4'b1111; end
         else if (f3 == 3'd4) begin r = a ^ b; c = 4'b0011; end
         else if (f3 == 3'd5 && !f7) begin r = a >> sh; c = 4'b0101; end
         else if (f3 == 3'd5) begin r = $unsigned($signed(a) >>> sh); c = 4'b1101; end
         else if (f3 == 3'd6) begin r = a | b; c = 4'b0001; end
         else begin r = a & b; c = 4'b0000; end
      end else if (f3 == 3'd0) begin
         r = a * b; c = 4'b1000; lat = MUL_LAT;
      end else il = 1'b1;
   endfunction

   // Issue one op, wait for out_valid, capture outputs, then release DONE.
   task automatic do_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input bit busy_rdy,
                        output logic [31:0] r, output logic [3:0] c, output logic z,
                        output logic il, output int lat);
      int w;
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 100) begin @(negedge clk); w++; end
      chk("in_ready_before_issue", {63'd0, bus.in_ready}, 64'd1);
      bus.alu_op = op; bus.funct3 = f3; bus.funct7b5 = f7;
      bus.op_a = a; bus.op_b = b; bus.in_valid = 1'b1; bus.out_ready = busy_rdy;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         bus.in_valid = 1'b0;
         bus.op_a = $urandom;
         bus.op_b = $urandom;
      end while (!bus.out_valid && lat < 100);
      r = bus.result; c = bus.alu_ctrl; z = bus.zero; il = bus.illegal;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] r, er;
      logic [3:0]  c, ec;
      logic        z, il, eil;
      int          lat, elat, seen;
      logic [1:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] a, b;

      vecs[0]  = '{2'd2, 3'd0, 1'b1, 32'd5, 32'd7, 32'hFFFFFFFE, 4'b0110, 1'b0, 1};
      vecs[1]  = '{2'd2, 3'd5, 1'b1, 32'h80000000, 32'd4, 32'hF8000000, 4'b1101, 1'b0, 1};
      vecs[2]  = '{2'd2, 3'd5, 1'b0, 32'h80000000, 32'd4, 32'h08000000, 4'b0101, 1'b0, 1};
      vecs[3]  = '{2'd2, 3'd3, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b1111, 1'b0, 1};
      vecs[4]  = '{2'd3, 3'd0, 1'b0, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 4'b1000, 1'b0, 33};
      vecs[5]  = '{2'd3, 3'd2, 1'b0, 32'd9, 32'd9, 32'd0, 4'b0010, 1'b1, 1};
      vecs[6]  = '{2'd0, 3'd7, 1'b1, 32'd2, 32'd3, 32'd5, 4'b0010, 1'b0, 1};
      vecs[7]  = '{2'd1, 3'd0, 1'b0, 32'd0, 32'd1, 32'hFFFFFFFF, 4'b0110, 1'b0, 1};
      vecs[8]  = '{2'd2, 3'd2, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b0111, 1'b0, 1};
      vecs[9]  = '{2'd2, 3'd1, 1'b0, 32'd1, 32'h25, 32'h20, 4'b0100, 1'b0, 1};
      vecs[10] = '{2'd2, 3'd4, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0011, 1'b0, 1};
      vecs[11] = '{2'd2, 3'd6, 1'b0, 32'h000000F0, 32'h0000000F, 32'h000000FF, 4'b0001, 1'b0, 1};
      vecs[12] = '{2'd2, 3'd7, 1'b0, 32'h000000F0, 32'h0000000F, 32'd0, 4'b0000, 1'b0, 1};
      vecs[13] = '{2'd3, 3'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 4'b1000, 1'b0, 33};
      vecs[14] = '{2'd2, 3'd0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0010, 1'b0, 1};
      vecs[15] = '{2'd3, 3'd0, 1'b1, 32'd3, 32'd4, 32'd12, 4'b1000, 1'b0, 33};

      // Reset with a request pending: it must be ignored.
      bus.in_valid = 1'b1; bus.alu_op = 2'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
      bus.op_a = 32'd1; bus.op_b = 32'd1; bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_result", {32'd0, bus.result}, 64'd0);
      chk("rst_zero", {63'd0, bus.zero}, 64'd0);
      chk("rst_illegal", {63'd0, bus.illegal}, 64'd0);
      chk("rst_alu_ctrl", {60'd0, bus.alu_ctrl}, 64'h2);
      rst_n = 1'b1; bus.in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("post_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);

      for (int i = 0; i < 16; i++) begin
         do_op(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, 1'b0, r, c, z, il, lat);
         chk($sformatf("vec%0d_result", i), {32'd0, r}, {32'd0, vecs[i].res});
         chk($sformatf("vec%0d_ctrl", i), {60'd0, c}, {60'd0, vecs[i].ctrl});
         chk($sformatf("vec%0d_illegal", i), {63'd0, il}, {63'd0, vecs[i].ill});
         chk($sformatf("vec%0d_zero", i), {63'd0, z}, {63'd0, (vecs[i].res == 32'd0)});
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      end

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3)); f3 = 3'($urandom); f7 = 1'($urandom);
         a = $urandom; b = $urandom;
         if (i % 4 == 0) f3 = 3'd0;
         model(op, f3, f7, a, b, er, ec, eil, elat);
         do_op(op, f3, f7, a, b, 1'($urandom_range(0, 1)), r, c, z, il, lat);
         chk($sformatf("rnd%0d_result", i), {32'd0, r}, {32'd0, er});
         chk($sformatf("rnd%0d_ctrl", i), {60'd0, c}, {60'd0, ec});
         chk($sformatf("rnd%0d_illegal", i), {63'd0, il}, {63'd0, eil});
         chk($sformatf("rnd%0d_zero", i), {63'd0, z}, {63'd0, (er == 32'd0)});
         chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(elat));
      end

      // Hold in DONE with a new request pending, then release with in_valid=1.
      @(negedge clk);
      bus.alu_op = 2'd0; bus.op_a = 32'd10; bus.op_b = 32'd3; bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.op_a = 32'd2; bus.op_b = 32'd3;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("hold%0d_out_valid", k), {63'd0, bus.out_valid}, 64'd1);
         chk($sformatf("hold%0d_result", k), {32'd0, bus.result}, 64'd13);
         chk($sformatf("hold%0d_in_ready", k), {63'd0, bus.in_ready}, 64'd0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("release_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("next_accept_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("next_accept_result", {32'd0, bus.result}, 64'd5);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;

      // Reset during a multiply: no result may ever appear.
      @(negedge clk);
      bus.alu_op = 2'd3; bus.funct3 = 3'd0; bus.op_a = 32'd7; bus.op_b = 32'd9;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      bus.alu_op = 2'd0; bus.in_valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b1; bus.in_valid = 1'b0;
      chk("midmul_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("midmul_rst_result", {32'd0, bus.result}, 64'd0);
      chk("midmul_rst_alu_ctrl", {60'd0, bus.alu_ctrl}, 64'h2);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      bus.out_ready = 1'b0;
      chk("midmul_no_out_valid", 64'(seen), 64'd0);
      do_op(2'd0, 3'd0, 1'b0, 32'd2, 32'd3, 1'b0, r, c, z, il, lat);
      chk("after_abort_add_result", {32'd0, r}, 64'd5);
      chk("after_abort_add_latency", 64'(lat), 64'd1);

      // Reset while in DONE discards the presented result.
      @(negedge clk);
      bus.alu_op = 2'd1; bus.op_a = 32'd9; bus.op_b = 32'd4; bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("done_before_rst", {63'd0, bus.out_valid}, 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("done_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("done_rst_result", {32'd0, bus.result}, 64'd0);

      // MUL_EN=0 instance treats a multiply as a single-cycle illegal op.
      repeat (3) @(negedge clk);
      bus.alu_op = 2'd3; bus.funct3 = 3'd0; bus.op_a = 32'd6; bus.op_b = 32'd7;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("nomul_out_valid", {63'd0, bus_nm.out_valid}, 64'd1);
      chk("nomul_illegal", {63'd0, bus_nm.illegal}, 64'd1);
      chk("nomul_result", {32'd0, bus_nm.result}, 64'd0);
      chk("nomul_alu_ctrl", {60'd0, bus_nm.alu_ctrl}, 64'h2);
      seen = 0;
      while (!bus.out_valid && seen < 100) begin @(negedge clk); seen++; end
      chk("mul_en_result", {32'd0, bus.result}, 64'd42);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
